// File: rtl/time_keep_ctrl_if.sv
// Purpose: bundles the tick/button inputs and the time/display outputs of the time-keeping controller.
// Latency: none, wiring only.
// Backpressure: none; level signals and single-cycle pulses only.
interface time_keep_ctrl_if;
    // Inputs to the controller
    logic       secTick;
    logic       modeBtn;
    logic       incBtn;
    // Outputs from the controller
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] setMode;
    logic       hrVisible;
    logic       minVisible;
    logic       dayPulse;

    // Stimulus side: drives tick and buttons, observes the time registers
    modport master (
        output secTick,
        output modeBtn,
        output incBtn,
        input  hours,
        input  minutes,
        input  seconds,
        input  setMode,
        input  hrVisible,
        input  minVisible,
        input  dayPulse
    );

    // Controller side
    modport slave (
        input  secTick,
        input  modeBtn,
        input  incBtn,
        output hours,
        output minutes,
        output seconds,
        output setMode,
        output hrVisible,
        output minVisible,
        output dayPulse
    );
endinterface

// File: rtl/time_keep_ctrl.sv
// Purpose: hh:mm:ss time registers with tick counting, button set mode, field blink and set-mode timeout.
// Latency: seconds update on the 3rd clkMSec edge after secTick is first sampled high; buttons act on the sampling edge.
// Backpressure: none; every tick and button edge is consumed in the cycle it is detected.
module time_keep_ctrl #(
    parameter int HOURS_MAX    = 24,
    parameter int BLINK_PERIOD = 500,
    parameter int SET_TIMEOUT  = 10000
) (
    input  logic             clkMSec,
    input  logic             reset,
    time_keep_ctrl_if.slave  timeBus
);

    localparam int BLINK_W = $clog2(BLINK_PERIOD + 1);
    localparam int TO_W    = $clog2(SET_TIMEOUT + 1);

    localparam logic [4:0]         HR_LAST    = 5'(HOURS_MAX - 1);
    localparam logic [5:0]         MS_LAST    = 6'd59;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIOD - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(SET_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } ctrlState_t;

    ctrlState_t         state;

    // Tick synchroniser and edge-detect history
    logic               secSync1;
    logic               secSync2;
    logic               secSyncDly;
    logic               modePrev;
    logic               incPrev;

    // Registered outputs
    logic [4:0]         hoursReg;
    logic [5:0]         minutesReg;
    logic [5:0]         secondsReg;
    logic               hrVisibleReg;
    logic               minVisibleReg;
    logic               dayPulseReg;

    // Set-mode housekeeping
    logic [BLINK_W-1:0] blinkCnt;
    logic               blinkPhase;
    logic [TO_W-1:0]    timeoutCnt;

    // Decoded events and wrapped increments
    logic               tick;
    logic               modeEvt;
    logic               incEvt;
    logic               blinkTerm;
    logic               timeoutHit;
    logic [4:0]         hoursNext;
    logic [5:0]         minutesNext;
    logic [5:0]         secondsNext;

    // Synchronise secTick into clkMSec and keep one-cycle history for edge detection
    always_ff @(posedge clkMSec) begin
        if (reset) begin
            secSync1   <= 1'b0;
            secSync2   <= 1'b0;
            secSyncDly <= 1'b0;
            modePrev   <= 1'b0;
            incPrev    <= 1'b0;
        end else begin
            secSync1   <= timeBus.secTick;
            secSync2   <= secSync1;
            secSyncDly <= secSync2;
            modePrev   <= timeBus.modeBtn;
            incPrev    <= timeBus.incBtn;
        end
    end

    // Rising-edge events and the wrap-around successor of each time field
    always_comb begin
        tick        = secSync2 & ~secSyncDly;
        modeEvt     = timeBus.modeBtn & ~modePrev;
        incEvt      = timeBus.incBtn & ~incPrev;
        blinkTerm   = (blinkCnt == BLINK_LAST);
        timeoutHit  = (timeoutCnt == TO_LAST);
        hoursNext   = (hoursReg == HR_LAST) ? 5'd0 : hoursReg + 5'd1;
        minutesNext = (minutesReg == MS_LAST) ? 6'd0 : minutesReg + 6'd1;
        secondsNext = (secondsReg == MS_LAST) ? 6'd0 : secondsReg + 6'd1;
    end

    // Mode FSM: counting in RUN, field editing, blink and timeout in the set states
    always_ff @(posedge clkMSec) begin
        if (reset) begin
            state         <= RUN;
            hoursReg      <= 5'd0;
            minutesReg    <= 6'd0;
            secondsReg    <= 6'd0;
            hrVisibleReg  <= 1'b1;
            minVisibleReg <= 1'b1;
            dayPulseReg   <= 1'b0;
            blinkCnt      <= '0;
            blinkPhase    <= 1'b0;
            timeoutCnt    <= '0;
        end else begin
            dayPulseReg <= 1'b0;
            case (state)
                RUN: begin
                    hrVisibleReg  <= 1'b1;
                    minVisibleReg <= 1'b1;
                    // A tick coincident with modeBtn is still applied in full
                    if (tick) begin
                        secondsReg <= secondsNext;
                        if (secondsReg == MS_LAST) begin
                            minutesReg <= minutesNext;
                            if (minutesReg == MS_LAST) begin
                                hoursReg <= hoursNext;
                                if (hoursReg == HR_LAST) begin
                                    dayPulseReg <= 1'b1;
                                end
                            end
                        end
                    end
                    if (modeEvt) begin
                        state      <= SET_HR;
                        blinkCnt   <= '0;
                        blinkPhase <= 1'b1;
                        timeoutCnt <= '0;
                    end
                end

                SET_HR, SET_MIN: begin
                    // Seconds sit at zero for the whole edit session
                    secondsReg <= 6'd0;
                    if (modeEvt) begin
                        // Mode wins over a simultaneous increment
                        state         <= (state == SET_HR) ? SET_MIN : RUN;
                        blinkCnt      <= '0;
                        blinkPhase    <= 1'b1;
                        timeoutCnt    <= '0;
                        hrVisibleReg  <= 1'b1;
                        minVisibleReg <= 1'b1;
                    end else if (incEvt) begin
                        // Field wraps on its own, no carry and no dayPulse
                        if (state == SET_HR) begin
                            hoursReg <= hoursNext;
                        end else begin
                            minutesReg <= minutesNext;
                        end
                        blinkCnt      <= '0;
                        blinkPhase    <= 1'b1;
                        timeoutCnt    <= '0;
                        hrVisibleReg  <= 1'b1;
                        minVisibleReg <= 1'b1;
                    end else if (timeoutHit) begin
                        // Abandoned edit: keep the field values and resume counting
                        state         <= RUN;
                        blinkCnt      <= '0;
                        blinkPhase    <= 1'b1;
                        timeoutCnt    <= '0;
                        hrVisibleReg  <= 1'b1;
                        minVisibleReg <= 1'b1;
                    end else begin
                        timeoutCnt <= timeoutCnt + TO_W'(1);
                        if (blinkTerm) begin
                            blinkCnt      <= '0;
                            blinkPhase    <= ~blinkPhase;
                            hrVisibleReg  <= (state == SET_HR) ? ~blinkPhase : 1'b1;
                            minVisibleReg <= (state == SET_MIN) ? ~blinkPhase : 1'b1;
                        end else begin
                            blinkCnt <= blinkCnt + BLINK_W'(1);
                        end
                    end
                end

                default: begin
                    state         <= RUN;
                    blinkCnt      <= '0;
                    blinkPhase    <= 1'b1;
                    timeoutCnt    <= '0;
                    hrVisibleReg  <= 1'b1;
                    minVisibleReg <= 1'b1;
                end
            endcase
        end
    end

    assign timeBus.hours      = hoursReg;
    assign timeBus.minutes    = minutesReg;
    assign timeBus.seconds    = secondsReg;
    assign timeBus.setMode    = state;
    assign timeBus.hrVisible  = hrVisibleReg;
    assign timeBus.minVisible = minVisibleReg;
    assign timeBus.dayPulse   = dayPulseReg;

endmodule

// File: tb/tb_time_keep_ctrl.sv
// Purpose: directed self-checking bench for time_keep_ctrl.
// Latency: inputs driven and outputs sampled 1 ns after each rising clkMSec edge.
// Backpressure: none; fixed-length stimulus, every wait is a bounded cycle count.
module tb_time_keep_ctrl;

    logic clkMSec = 1'b0;
    logic reset;
    int   errCnt = 0;
    int   chkCnt = 0;

    time_keep_ctrl_if timeBus();

    time_keep_ctrl #(
        .HOURS_MAX    (24),
        .BLINK_PERIOD (500),
        .SET_TIMEOUT  (10000)
    ) dut (
        .clkMSec (clkMSec),
        .reset   (reset),
        .timeBus (timeBus)
    );

    always #5 clkMSec = ~clkMSec;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chkCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkTime(input string tag, input int h, input int m, input int s);
        checkVal({tag, ".hours"},   32'(timeBus.hours),   h);
        checkVal({tag, ".minutes"}, 32'(timeBus.minutes), m);
        checkVal({tag, ".seconds"}, 32'(timeBus.seconds), s);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clkMSec);
        #1;
    endtask

    task automatic pulseMode();
        timeBus.modeBtn = 1'b1;
        step(1);
        timeBus.modeBtn = 1'b0;
        step(1);
    endtask

    task automatic pulseInc(input int n);
        for (int k = 0; k < n; k++) begin
            timeBus.incBtn = 1'b1;
            step(1);
            timeBus.incBtn = 1'b0;
            step(1);
        end
    endtask

    // Raise secTick and stop right after the edge that applies the tick
    task automatic tickRise();
        timeBus.secTick = 1'b1;
        step(3);
    endtask

    task automatic tickFall(input int hiRest, input int lo);
        step(hiRest);
        timeBus.secTick = 1'b0;
        step(lo);
    endtask

    task automatic sendTicks(input int n);
        for (int k = 0; k < n; k++) begin
            tickRise();
            tickFall(2, 3);
        end
    endtask

    initial begin
        reset           = 1'b1;
        timeBus.secTick = 1'b0;
        timeBus.modeBtn = 1'b0;
        timeBus.incBtn  = 1'b0;
        step(2);

        // Reset state
        checkTime("rst", 0, 0, 0);
        checkVal("rst.setMode", 32'(timeBus.setMode), 0);
        checkVal("rst.hrVis", 32'(timeBus.hrVisible), 1);
        checkVal("rst.minVis", 32'(timeBus.minVisible), 1);
        checkVal("rst.dayPulse", 32'(timeBus.dayPulse), 0);
        reset = 1'b0;
        step(1);

        // 60 full-length ticks: update lands exactly on the 3rd edge after the rise
        for (int i = 0; i < 60; i++) begin
            timeBus.secTick = 1'b1;
            step(2);
            checkVal("tick.pre", 32'(timeBus.seconds), i);
            step(1);
            checkVal("tick.post", 32'(timeBus.seconds), (i + 1) % 60);
            step(497);
            timeBus.secTick = 1'b0;
            step(500);
        end
        checkTime("tick.final", 0, 1, 0);

        // Set mode from a clean start: hour wrap without carry, minute wrap
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
        pulseMode();
        checkVal("set.modeHr", 32'(timeBus.setMode), 1);
        checkVal("set.secZero", 32'(timeBus.seconds), 0);
        for (int j = 0; j < 25; j++) begin
            pulseInc(1);
            checkVal("set.hourInc", 32'(timeBus.hours), (j + 1) % 24);
            if (j == 23) begin
                checkVal("set.hourWrapNoDay", 32'(timeBus.dayPulse), 0);
            end
        end
        checkVal("set.noCarryMin", 32'(timeBus.minutes), 0);
        pulseMode();
        checkVal("set.modeMin", 32'(timeBus.setMode), 2);
        pulseInc(61);
        checkTime("set.min61", 1, 1, 0);
        pulseMode();
        checkVal("set.modeRun", 32'(timeBus.setMode), 0);

        // Preload 23:59:58 and roll over midnight
        pulseMode();
        pulseInc(22);
        pulseMode();
        pulseInc(58);
        pulseMode();
        checkTime("pre.set", 23, 59, 0);
        sendTicks(58);
        checkTime("pre.58", 23, 59, 58);
        tickRise();
        checkTime("day.59", 23, 59, 59);
        checkVal("day.noPulse", 32'(timeBus.dayPulse), 0);
        tickFall(2, 3);
        tickRise();
        checkTime("day.wrap", 0, 0, 0);
        checkVal("day.pulse", 32'(timeBus.dayPulse), 1);
        checkVal("day.mode", 32'(timeBus.setMode), 0);
        step(1);
        checkVal("day.pulseEnd", 32'(timeBus.dayPulse), 0);
        tickFall(1, 3);

        // Mode and increment on the same edge in SET_HR
        pulseMode();
        timeBus.modeBtn = 1'b1;
        timeBus.incBtn  = 1'b1;
        step(1);
        checkVal("sim.mode", 32'(timeBus.setMode), 2);
        checkVal("sim.hours", 32'(timeBus.hours), 0);
        timeBus.modeBtn = 1'b0;
        timeBus.incBtn  = 1'b0;
        step(1);
        pulseMode();
        checkVal("sim.backRun", 32'(timeBus.setMode), 0);

        // Tick coincident with modeBtn at 00:00:59
        sendTicks(59);
        checkTime("coin.pre", 0, 0, 59);
        timeBus.secTick = 1'b1;
        step(2);
        timeBus.modeBtn = 1'b1;
        step(1);
        checkVal("coin.min", 32'(timeBus.minutes), 1);
        checkVal("coin.mode", 32'(timeBus.setMode), 1);
        timeBus.modeBtn = 1'b0;
        step(1);
        checkTime("coin.after", 0, 1, 0);
        timeBus.secTick = 1'b0;
        step(3);

        // Ticks are ignored in a set state
        sendTicks(1);
        checkTime("setTick.ignored", 0, 1, 0);

        // SET_MIN idle: blink every 500 cycles, then timeout back to RUN
        pulseMode();
        checkVal("blink.mode", 32'(timeBus.setMode), 2);
        checkVal("blink.entryVis", 32'(timeBus.minVisible), 1);
        step(498);
        checkVal("blink.499", 32'(timeBus.minVisible), 1);
        step(1);
        checkVal("blink.500", 32'(timeBus.minVisible), 0);
        step(499);
        checkVal("blink.999", 32'(timeBus.minVisible), 0);
        step(1);
        checkVal("blink.1000", 32'(timeBus.minVisible), 1);
        checkVal("blink.hrVis", 32'(timeBus.hrVisible), 1);
        step(8999);
        checkVal("to.9999mode", 32'(timeBus.setMode), 2);
        checkVal("to.9999vis", 32'(timeBus.minVisible), 0);
        step(1);
        checkVal("to.mode", 32'(timeBus.setMode), 0);
        checkTime("to.kept", 0, 1, 0);
        checkVal("to.minVis", 32'(timeBus.minVisible), 1);

        // Reset in SET_MIN at 12:34
        pulseMode();
        pulseInc(12);
        pulseMode();
        pulseInc(33);
        checkTime("mid.preset", 12, 34, 0);
        checkVal("mid.mode", 32'(timeBus.setMode), 2);
        reset = 1'b1;
        step(1);
        checkTime("mid.rst", 0, 0, 0);
        checkVal("mid.rstMode", 32'(timeBus.setMode), 0);
        checkVal("mid.rstHrVis", 32'(timeBus.hrVisible), 1);
        checkVal("mid.rstMinVis", 32'(timeBus.minVisible), 1);
        checkVal("mid.rstDay", 32'(timeBus.dayPulse), 0);
        reset = 1'b0;
        step(1);
        sendTicks(1);
        checkTime("mid.resume", 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule

// File: doc/time_keep_ctrl.md
Name: time_keep_ctrl

Overview:
- Controller that sequences the digital-clock time registers: hours, minutes and seconds.
- Counts on a once-per-second tick, produced by the clock-synchronisation block as a level that rises once per second.
- Provides a button-driven set mode: select field, increment field.
- Sits between the tick synchroniser and the display/BCD driver, all on the millisecond system clock.

Parameters:
HOURS_MAX, 24, hour modulus; hours wrap from HOURS_MAX-1 to 0
BLINK_PERIOD, 500, clkMSec cycles per blink half-period in set mode
SET_TIMEOUT, 10000, idle clkMSec cycles in a set state before auto-return to RUN

Ports:
clkMSec  input  1  system clock, 1 kHz nominal; all logic on posedge
reset  input  1  synchronous, active-high reset
secTick  input  1  once-per-second level from the clock synchroniser; may be asynchronous to clkMSec
modeBtn  input  1  debounced mode button, level, synchronous to clkMSec
incBtn  input  1  debounced increment button, level, synchronous to clkMSec
hours  output  5  current hour, binary, 0..HOURS_MAX-1
minutes  output  6  current minute, binary, 0..59
seconds  output  6  current second, binary, 0..59
setMode  output  2  0=RUN, 1=SET_HR, 2=SET_MIN; 3 never driven
hrVisible  output  1  display enable for the hour field (blink)
minVisible  output  1  display enable for the minute field (blink)
dayPulse  output  1  one-cycle pulse on hour wrap to 0 from counting

Behaviour:
- Clock and reset: one clock (clkMSec); reset is synchronous and active-high.
- Reset values:
  - hours=0, minutes=0, seconds=0
  - setMode=0, state RUN
  - hrVisible=1, minVisible=1, dayPulse=0
  - sync flops, edge-detect history, blink counter and timeout counter all 0
- Reset mid-operation: any state returns to RUN with zeroed time on the next edge.
- secTick path:
  - Two-flop synchroniser, then rising-edge detect, giving an internal tick one cycle wide.
  - seconds updates on the 3rd posedge after secTick is first sampled high.
  - A level held high produces exactly one tick.
- Button path: rising-edge detect only. One press gives one event; held levels do not repeat.
- RUN state:
  - tick: seconds+1.
  - 59->0 carries minutes+1; minutes 59->0 carries hours+1; hours HOURS_MAX-1 -> 0 asserts dayPulse for that one cycle.
  - All carries resolve in the same cycle.
  - incBtn ignored.
- SET_HR / SET_MIN states:
  - Ticks ignored. seconds forced to 0 on entry to SET_HR and held at 0.
  - incBtn event increments the selected field only, with wrap: hours HOURS_MAX-1->0, minutes 59->0. No carry and no dayPulse.
- Mode transitions:
  - modeBtn event cycles RUN->SET_HR->SET_MIN->RUN.
  - On return to RUN, counting resumes from the next tick.
- Simultaneous events:
  - modeBtn and incBtn on the same cycle: mode transition taken, increment dropped.
  - Tick and modeBtn on the same cycle in RUN: tick applied (including carries), then state moves to SET_HR. Seconds are zeroed on the following cycle's entry action.
- Blink:
  - In a set state, the counter runs 0..BLINK_PERIOD-1; at terminal count it wraps and the blink phase toggles.
  - Counter cleared and phase forced visible on state entry and on every incBtn event.
  - Selected field visible = phase; the non-selected field is held at 1.
  - In RUN both visible signals are 1.
- Timeout:
  - The counter increments each cycle in a set state and clears on any button event or state change.
  - Reaching SET_TIMEOUT-1 forces RUN on the next edge; field values are kept.
- Outputs are registered; no combinational path from input to output.

Test Plan:
- Reset, then 60 secTick pulses (high 500 cycles, low 500) -> seconds 0..59 then 0, minutes=1, each update exactly 3 cycles after secTick rises.
- Preload 23:59:58 via set mode, run 2 ticks -> 00:00:00; dayPulse high exactly one cycle on the second tick; setMode=0.
- modeBtn, then incBtn x25 -> hours counts 1..23,0,1 (wrap, no carry), seconds=0; modeBtn, incBtn x61 -> minutes=1; modeBtn -> setMode=0.
- In SET_MIN with no buttons -> minVisible toggles every 500 cycles, hrVisible=1; after 10000 cycles setMode=0 and minute value unchanged.
- modeBtn and incBtn rise on the same cycle in SET_HR -> setMode=2, hours unchanged; tick coincident with modeBtn at 00:00:59 -> minutes=1, then seconds=0, setMode=1.
- Assert reset for one cycle in SET_MIN at 12:34 -> next cycle all outputs at reset values, setMode=0, visible signals=1.
